// File: rtl/npu_pkg.sv
// Shared NPU constants and the saturating narrow used by the neuron quantizer.
package npu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 16;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned       w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat_to_width = hi;
    else if (v < lo) sat_to_width = lo;
    else             sat_to_width = v;
  endfunction

endpackage

// File: rtl/dot_product.sv
// Signed N-element dot product; lane products are resized to the accumulator and summed with wrap.
module dot_product
  import npu_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic [N*DATA_WIDTH-1:0]  x,
  input  logic [N*DATA_WIDTH-1:0]  w,
  output logic signed [ACC_WIDTH-1:0] dp
);

  logic [N-1:0][ACC_WIDTH-1:0] p;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0]   xe, we;
    logic signed [2*DATA_WIDTH-1:0] prod;
    assign xe   = x[i*DATA_WIDTH +: DATA_WIDTH];
    assign we   = w[i*DATA_WIDTH +: DATA_WIDTH];
    assign prod = xe * we;
    // Signed size cast: sign-extends when widening, drops MSBs when narrowing.
    assign p[i] = ACC_WIDTH'(prod);
  end

  always_comb begin
    dp = '0;
    for (int i = 0; i < N; i++) dp = dp + $signed(p[i]);
  end

endmodule

// File: rtl/quantizer.sv
// Saturating narrow from accumulator width to data width; no shift or rounding.
module quantizer
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]  sum,
  output logic signed [DATA_WIDTH-1:0] pre
);

  assign pre = DATA_WIDTH'(sat_to_width(64'(sum), DATA_WIDTH));

endmodule

// File: rtl/relu.sv
// Rectifier: negative inputs become zero.
module relu
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  output logic signed [DATA_WIDTH-1:0] y
);

  assign y = a[DATA_WIDTH-1] ? '0 : a;

endmodule

// File: rtl/neuron_datapath.sv
// Single neuron: dot product + bias, saturate, ReLU, one output register.
module neuron_datapath
  import npu_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N*DATA_WIDTH-1:0]      x,
  input  logic [N*DATA_WIDTH-1:0]      w,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [ACC_WIDTH-1:0]  dp, sum;
  logic signed [DATA_WIDTH-1:0] pre, relu_out;
  logic signed [DATA_WIDTH-1:0] y_d, y_q;

  dot_product #(.N(N), .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_dot (
    .x (x),
    .w (w),
    .dp(dp)
  );

  // Bias is sign-extended by the size cast; the add wraps at ACC_WIDTH.
  assign sum = dp + ACC_WIDTH'(b);

  quantizer #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_quant (
    .sum(sum),
    .pre(pre)
  );

  relu #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
    .a(pre),
    .y(relu_out)
  );

  always_comb y_d = relu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: tb/tb_neuron_datapath.sv
// Directed and randomized checks of neuron_datapath against an integer reference model.
module tb_neuron_datapath;

  localparam int N  = 16;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N*DW-1:0]      x, w;
  logic signed [DW-1:0] b;
  logic signed [DW-1:0] y;

  int xa[N];
  int wa[N];
  int bv;
  int n_tests = 0;
  int n_fail  = 0;

  neuron_datapath #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .w    (w),
    .b    (b),
    .y    (y)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum, reduced mod 2^16 into signed range, clamp, ReLU.
  function automatic int wrap16(input longint v);
    longint m;
    m = v % 65536;
    if (m < 0) m += 65536;
    if (m >= 32768) m -= 65536;
    return int'(m);
  endfunction

  function automatic int model();
    longint s;
    int     t;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(xa[i]) * longint'(wa[i]);
    t = wrap16(longint'(wrap16(s)) + longint'(bv));
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return (t < 0) ? 0 : t;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      x[i*DW +: DW] = 8'(xa[i]);
      w[i*DW +: DW] = 8'(wa[i]);
    end
    b = 8'(bv);
  endtask

  task automatic set_vec(input int xv, input int wv, input int bb);
    for (int i = 0; i < N; i++) begin
      xa[i] = xv;
      wa[i] = wv;
    end
    bv = bb;
    drive();
  endtask

  task automatic check(input string tag, input int exp);
    n_tests++;
    assert (y === 8'(exp))
    else begin
      n_fail++;
      $error("FAIL %s: y=%0d expected %0d", tag, y, exp);
    end
  endtask

  task automatic step_check(input string tag, input int exp);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    set_vec(1, 2, 3);
    #1;
    check("reset_async_initial", 0);
    step_check("reset_held_1", 0);
    step_check("reset_held_2", 0);

    @(negedge clk);
    rst_n = 1'b1;
    step_check("release_first_edge", 35);

    @(negedge clk); set_vec(1, -1, 0);       step_check("relu_neg16", 0);
    @(negedge clk); set_vec(0, 0, -5);       step_check("relu_bias_neg", 0);
    @(negedge clk); set_vec(127, 1, 0);      step_check("sat_high_2032", 127);
    @(negedge clk); set_vec(0, 0, 127);      step_check("bias_max", 127);
    @(negedge clk); set_vec(-128, -128, 5);  step_check("acc_wrap_to_zero", 5);
    @(negedge clk); set_vec(127, 127, 0);    step_check("acc_wrap_negative", 0);

    // Back-to-back vectors; y trails by one edge.
    @(negedge clk); set_vec(1, 2, 3);        step_check("pipe_35", 35);
    @(negedge clk); set_vec(127, 1, 0);      step_check("pipe_127", 127);
    @(negedge clk); set_vec(0, 0, 0);        step_check("pipe_0", 0);

    // Asynchronous reset between edges while a non-zero result is held.
    @(negedge clk); set_vec(1, 2, 3);        step_check("pre_reset_35", 35);
    #2 rst_n = 1'b0;
    #1 check("midstream_async_reset", 0);
    step_check("midstream_reset_held", 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_check("midstream_release", 35);

    // Random vectors: wide range stresses wrap/saturation, narrow range hits the linear region.
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (k % 2 == 0) begin
          xa[i] = int'($urandom_range(0, 255)) - 128;
          wa[i] = int'($urandom_range(0, 255)) - 128;
        end else begin
          xa[i] = int'($urandom_range(0, 6)) - 3;
          wa[i] = int'($urandom_range(0, 6)) - 3;
        end
      end
      bv = int'($urandom_range(0, 255)) - 128;
      drive();
      step_check($sformatf("random_%0d", k), model());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_datapath.md
# neuron_datapath

Single-neuron inference datapath: a signed N-element dot product of an input vector and a weight vector, plus a signed bias, saturated down to the data width and passed through a ReLU. The result is held in one output register. The block is the compute element of the NPU's perceptron layer and is replicated per neuron. It is purely feed-forward, with no handshake and no internal state other than the output register.

## Interface
Parameters:
- N, 16: vector length (number of elements).
- DATA_WIDTH, 8: element, weight, bias and output width (signed two's complement).
- ACC_WIDTH, 16: accumulator width. Must satisfy ACC_WIDTH ≥ DATA_WIDTH.

Ports:
- clk  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous reset, active low.
- x  in  N*DATA_WIDTH  packed signed input vector. Element i = x[i*DATA_WIDTH +: DATA_WIDTH].
- w  in  N*DATA_WIDTH  packed signed weights, packed the same way as x.
- b  in  DATA_WIDTH  signed bias.
- y  out  DATA_WIDTH  signed activated output (registered).

## Operation
- **Products.** p_i = x_i * w_i, computed as a full 2*DATA_WIDTH signed product.
- **Accumulation.** Each product is sign-extended or truncated to ACC_WIDTH, then summed as dp = Σ p_i. The sum wraps modulo 2^ACC_WIDTH, with no saturation in the accumulator.
- **Bias add.** sum = dp + sign_extend(b, ACC_WIDTH). This also wraps modulo 2^ACC_WIDTH.
- **Quantize.** pre = clamp(sum, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1). The clamp is saturation only, with no shift or rounding; in-range values pass through unchanged.
- **Activation.** relu_out = (pre < 0) ? 0 : pre.
- **Output register.** y <= relu_out on every rising clk edge while rst_n is high. Inputs are sampled every cycle with no enable.
- **Output range.** y is always in [0, 2^(DATA_WIDTH-1)-1].

## Timing
- **Datapath.** Dot product, bias add, quantize and ReLU are all combinational in the same cycle.
- **Latency.** Inputs stable before rising edge k appear on y immediately after edge k, i.e. one-cycle latency. Throughput is one result per cycle.
- **Reset.** When rst_n goes low, y = 0 immediately, independent of clk. While rst_n is low, y holds 0 regardless of the inputs.
- **Reset release.** The first rising edge with rst_n high loads relu_out for the inputs present at that edge.
- **Reset mid-stream.** Any in-flight result is discarded and y is forced to 0. There is no other state to recover.
- **Simulation output.** No simulation-only output (no $display) in the RTL.

## Structure
- **Shared package** (npu_pkg): default DATA_WIDTH/ACC_WIDTH constants and a saturating-clamp function (sat_to_width).
- **Sub-modules**, all combinational:
  - dot_product (N, DATA_WIDTH, ACC_WIDTH): x, w in; dp out.
  - quantizer (DATA_WIDTH, ACC_WIDTH): saturating narrow.
  - relu (DATA_WIDTH).
- **Top level.** neuron_datapath instantiates the three sub-modules, performs the bias sign-extension and addition, and owns the output register.
- **Unpacking.** Unpacking of x and w into arrays is done with a generate loop inside dot_product.

## Test plan
All cases use N=16, DATA_WIDTH=8, ACC_WIDTH=16.
- **Reset:** drive rst_n=0 with arbitrary inputs and no clock edge → y=0 immediately; y stays 0 across clocks while reset is held.
- **Basic positive:** x_i=1, w_i=2, b=3 → dp=32, sum=35 → y=35 one cycle later.
- **Negative clipped by ReLU:** x_i=1, w_i=-1, b=0 → sum=-16 → y=0. Also x_i=0, w_i=0, b=-5 → y=0.
- **High saturation:** x_i=127, w_i=1, b=0 → sum=2032 → y=127. Also x_i=0, b=127 → y=127.
- **Accumulator wrap:** x_i=-128, w_i=-128, b=5 → 16×16384 wraps to 0 → sum=5 → y=5. Also x_i=127, w_i=127, b=0 → sum wraps to -4080 → y=0.
- **Pipelining and mid-stream reset:** apply a new vector each cycle (35, then 127, then 0 from the cases above) → y follows one cycle behind. Assert rst_n low asynchronously between edges → y=0 at once; after release the next edge loads the current result.
